// File: rtl/fifo_pausa_destino_pkg.sv
// rtl/fifo_pausa_destino_pkg.sv - shared sizes and default pause thresholds for the destination FIFOs
package fifo_pausa_destino_pkg;

  localparam int DATA_W          = 6;
  localparam int ADDR_W          = 3;
  localparam int DEPTH           = 1 << ADDR_W;
  localparam int UMBRAL_ALTO_DEF = 6;
  localparam int UMBRAL_BAJO_DEF = 2;

  typedef logic [DATA_W-1:0] palabra_t;
  typedef logic [ADDR_W:0]   ocupacion_t;

endpackage

// File: rtl/fifo_pausa_destino_memoria_fifo.sv
// rtl/fifo_pausa_destino_memoria_fifo.sv - dual-port register file, synchronous write, asynchronous read
module memoria_fifo
  import fifo_pausa_destino_pkg::*;
#(
  parameter int MEM_DATA_W = DATA_W,
  parameter int MEM_ADDR_W = ADDR_W
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [MEM_ADDR_W-1:0] wr_addr_i,
  input  logic [MEM_DATA_W-1:0] wr_data_i,
  input  logic [MEM_ADDR_W-1:0] rd_addr_i,
  output logic [MEM_DATA_W-1:0] rd_data_o
);

  localparam int MEM_DEPTH = 1 << MEM_ADDR_W;

  // No reset: contents are meaningless until written, the pointers guard every read.
  logic [MEM_DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_pausa_destino.sv
// rtl/fifo_pausa_destino.sv - per-destination output FIFO with hysteresis pause toward the arbiter
module fifo_pausa_destino
  import fifo_pausa_destino_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] D_in,
  input  logic              D_push,
  input  logic              D_pop,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  output logic [DATA_W-1:0] D_out,
  output logic              D_valid,
  output logic              D_pause,
  output logic              D_empty,
  output logic              D_full,
  output logic              D_error
);

  localparam logic [ADDR_W:0] LLENO = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              pause_q, pause_d;
  logic              error_q, error_d;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] rd_data;

  memoria_fifo #(
    .MEM_DATA_W (DATA_W),
    .MEM_ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (D_in),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign D_empty = (count_q == '0);
  assign D_full  = (count_q == LLENO);
  assign pop_ok  = D_pop & ~D_empty;
  // A pop frees the slot the push needs, so a full FIFO can still take a word.
  assign push_ok = D_push & (~D_full | pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    dout_d   = pop_ok ? rd_data : dout_q;
    valid_d  = pop_ok;
    pause_d  = (count_d >= umbral_alto) | (pause_q & (count_d > umbral_bajo));
    error_d  = error_q | (D_push & D_full & ~D_pop) | (D_pop & D_empty);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      pause_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      pause_q  <= pause_d;
      error_q  <= error_d;
    end
  end

  assign D_out   = dout_q;
  assign D_valid = valid_q;
  assign D_pause = pause_q;
  assign D_error = error_q;

endmodule
